johnson_seq_decoder: RTL and testbench
======================================

// Module: johnson_seq_decoder
// PURPOSE
//  Receive-side checker/decoder for twisted-ring (Johnson) counter codes.
//  - Samples a WIDTH-bit Johnson code and converts it to a binary state index 0..2*WIDTH-1.
//  - Flags illegal code words and out-of-sequence steps.
//  - Locks after LOCK_THRESH consecutive correct steps.
//  - Sits downstream of the twisted ring counter, or on any link carrying its code.
// PARAMETERS
//  WIDTH        4  code width; sequence length 2*WIDTH; IW = $clog2(2*WIDTH)
//  LOCK_THRESH  3  consecutive correct steps needed to enter LOCKED (1..15)
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      synchronous active-low reset
//  in_valid      in   1      code_in is sampled only when high
//  code_in       in   WIDTH  Johnson code word
//  count_out     out  IW     decoded binary index of last legal code
//  count_valid   out  1      1-cycle pulse: count_out updated
//  locked        out  1      high while the FSM is in LOCKED
//  illegal_code  out  1      1-cycle pulse: sampled word is not a legal Johnson code
//  seq_error     out  1      1-cycle pulse: legal code but not expected successor (any state except SEARCH)
//  err_count     out  8      saturating error counter (see CONFIGURATION)
// BEHAVIOUR
//  - Sequence: next = {~code[0], code[WIDTH-1:1]}.
//    WIDTH=4: 0000,1000,1100,1110,1111,0111,0011,0001,0000 ...
//  - Index k, 0<=k<=WIDTH: top k bits are 1, rest 0.
//  - Index k, WIDTH<k<2W: top k-WIDTH bits are 0, rest 1.
//  - Any other word is illegal.
//  - All outputs are registered; latency is 1 clk from sampled code_in to outputs.
//  - Reset (reset_n=0 at posedge): state=SEARCH; lock_cnt=0; last_code=0.
//    All outputs reset to 0.
//  - in_valid=0: state, count_out and locked hold; all pulses are 0.
//  - Legal code equal to last_code is a stall:
//    count_valid=1, no error, lock_cnt unchanged.
//  - FSM, on in_valid=1 (E = expected successor of last_code):
//    SEARCH: legal  -> CHECK, lock_cnt=1, last_code=code, count_valid=1
//            illegal-> illegal_code=1, stay SEARCH
//    CHECK : ==E    -> lock_cnt++; lock_cnt reaching LOCK_THRESH -> LOCKED
//            legal!=E -> seq_error=1, lock_cnt=1, restart CHECK on new code
//            illegal-> illegal_code=1 -> SEARCH, lock_cnt=0
//    LOCKED: ==E    -> stay; count_valid=1
//            legal!=E -> seq_error=1 -> CHECK, lock_cnt=1
//            illegal-> illegal_code=1 -> SEARCH; locked drops next cycle
//  - Wrap: after index 2W-1 (e.g. 0001), E = 0000 (index 0). This is not an error.
//  - An illegal word never updates count_out or last_code.
//  - illegal_code and seq_error are mutually exclusive.
//  - LOCK_THRESH=1: first legal code goes SEARCH -> CHECK; the next correct step goes to LOCKED.
//  - Reset mid-stream overrides everything; the first legal code after reset enters CHECK.
// CONFIGURATION
//  JSD_ERR_COUNTER_EN defined:
//  - err_count increments on each illegal_code or seq_error pulse.
//  - Saturates at 8'hFF; cleared only by reset.
//  JSD_ERR_COUNTER_EN undefined:
//  - No counter logic; err_count is tied to 8'h00.
// TESTING (WIDTH=4, LOCK_THRESH=3)
//  1. Reset, then feed 0000,1000,1100 on consecutive valid cycles
//     -> count_out 0,1,2; locked=1 the cycle after 1100 is sampled.
//  2. Locked, run 1111,0111,0011,0001,0000
//     -> count_out 4,5,6,7,0; no pulses at the wrap.
//  3. Locked at 1100, feed 0110
//     -> illegal_code=1, locked=0, count_out stays 2, err_count=1 (macro on).
//  4. Locked at 1000, feed 1110
//     -> seq_error=1, CHECK, count_out=3.
//     Then 1111,0111 -> LOCKED again.
//  5. Locked, in_valid low 5 cycles, then repeat the same code
//     -> outputs hold; stall accepted, no error.
//  6. Assert reset_n=0 in LOCKED -> next cycle all outputs 0, state SEARCH.
//     Also 300 illegal words -> err_count=8'hFF (macro on) or 8'h00 (macro off).

Source files
------------

// File: rtl/johnson_seq_decoder.sv
// -----------------------------------------------------------------------------
// johnson_seq_decoder
//
// Receive-side checker for twisted-ring (Johnson) counter codes. Each sampled
// word is decoded to its binary position 0..2*WIDTH-1 and checked against the
// expected successor of the last legal word. The FSM (SEARCH/CHECK/LOCKED)
// declares lock after LOCK_THRESH consecutive correct steps. All outputs are
// registered, so results appear one clock after the word is sampled.
//
// Optional feature macro: JSD_ERR_COUNTER_EN
//   defined   : err_count is a saturating count of illegal_code/seq_error pulses
//   undefined : err_count is tied to 8'h00
//
// Ports
//   clk          in   1      rising-edge clock
//   reset_n      in   1      synchronous active-low reset
//   in_valid     in   1      code_in is sampled only when high
//   code_in      in   WIDTH  Johnson code word
//   count_out    out  IW     decoded index of the last legal word
//   count_valid  out  1      pulse: count_out updated
//   locked       out  1      high while in LOCKED
//   illegal_code out  1      pulse: sampled word is not a Johnson code
//   seq_error    out  1      pulse: legal word that is not the expected successor
//   err_count    out  8      saturating error counter (see macro above)
// -----------------------------------------------------------------------------
module johnson_seq_decoder #(
    parameter int WIDTH       = 4,
    parameter int LOCK_THRESH = 3,
    localparam int IW         = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] code_in,
    output logic [IW-1:0]    count_out,
    output logic             count_valid,
    output logic             locked,
    output logic             illegal_code,
    output logic             seq_error,
    output logic [7:0]       err_count
);

    localparam int N = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       lock_cnt_reg;
    logic [WIDTH-1:0] last_code_reg;
    logic [IW-1:0]    count_reg;
    logic             count_valid_reg;
    logic             locked_reg;
    logic             illegal_reg;
    logic             seq_error_reg;

    // ------------------------------------------------------------------
    // Decode: one constant pattern per sequence position, compared in
    // parallel. Positions 0..WIDTH fill ones from the MSB; positions
    // WIDTH+1..2*WIDTH-1 drain them again from the MSB.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pattern [N];
    logic [N-1:0]     match;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pattern
            if (gi <= WIDTH) begin : g_fill
                assign pattern[gi] = ~(ONES >> gi);
            end else begin : g_drain
                assign pattern[gi] = ONES >> (gi - WIDTH);
            end
            assign match[gi] = (code_in == pattern[gi]);
        end
    endgenerate

    logic [IW-1:0] code_index;

    always_comb begin
        code_index = '0;
        for (int k = 0; k < N; k++) begin
            if (match[k]) begin
                code_index = IW'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Step classification relative to the last legal word
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] expected_code;
    logic             is_legal;
    logic             is_stall;
    logic             is_expected;
    logic             illegal_next;
    logic             seq_error_next;
    logic [4:0]       lock_cnt_inc;

    assign expected_code  = {~last_code_reg[0], last_code_reg[WIDTH-1:1]};
    assign is_legal       = |match;
    assign is_stall       = (code_in == last_code_reg);
    assign is_expected    = (code_in == expected_code);
    assign illegal_next   = in_valid && !is_legal;
    // SEARCH has no reference word yet, so it can never report a sequence error.
    assign seq_error_next = in_valid && is_legal && (state_reg != SEARCH)
                            && !is_stall && !is_expected;
    assign lock_cnt_inc   = {1'b0, lock_cnt_reg} + 5'd1;

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= SEARCH;
            lock_cnt_reg    <= '0;
            last_code_reg   <= '0;
            count_reg       <= '0;
            count_valid_reg <= 1'b0;
            locked_reg      <= 1'b0;
            illegal_reg     <= 1'b0;
            seq_error_reg   <= 1'b0;
        end else begin
            count_valid_reg <= in_valid && is_legal;
            illegal_reg     <= illegal_next;
            seq_error_reg   <= seq_error_next;

            if (in_valid) begin
                if (!is_legal) begin
                    // Illegal words never touch count_out or last_code.
                    state_reg    <= SEARCH;
                    lock_cnt_reg <= '0;
                    locked_reg   <= 1'b0;
                end else begin
                    count_reg     <= code_index;
                    last_code_reg <= code_in;
                    case (state_reg)
                        SEARCH: begin
                            state_reg    <= CHECK;
                            lock_cnt_reg <= 4'd1;
                        end
                        CHECK: begin
                            if (is_stall) begin
                                // repeated word: hold the streak as is
                            end else if (is_expected) begin
                                lock_cnt_reg <= lock_cnt_inc[3:0];
                                if (lock_cnt_inc >= 5'(LOCK_THRESH)) begin
                                    state_reg  <= LOCKED;
                                    locked_reg <= 1'b1;
                                end
                            end else begin
                                // restart the streak on the new word
                                lock_cnt_reg <= 4'd1;
                            end
                        end
                        LOCKED: begin
                            if (!is_stall && !is_expected) begin
                                state_reg    <= CHECK;
                                lock_cnt_reg <= 4'd1;
                                locked_reg   <= 1'b0;
                            end
                        end
                        default: begin
                            state_reg    <= SEARCH;
                            lock_cnt_reg <= '0;
                            locked_reg   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign count_out    = count_reg;
    assign count_valid  = count_valid_reg;
    assign locked       = locked_reg;
    assign illegal_code = illegal_reg;
    assign seq_error    = seq_error_reg;

    // ------------------------------------------------------------------
    // Optional saturating error counter
    // ------------------------------------------------------------------
`ifdef JSD_ERR_COUNTER_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count_reg <= '0;
        end else if ((illegal_next || seq_error_next) && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_decoder
//
// Scoreboard bench: the driver applies one input set per cycle and pushes the
// expected output vector, produced by a position/streak reference model, into
// a queue; a monitor pops one entry per clock and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_johnson_seq_decoder;

    localparam int W      = 4;
    localparam int THRESH = 3;
    localparam int N      = 2 * W;
    localparam int IW     = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  code_in = '0;
    logic [IW-1:0] count_out;
    logic          count_valid;
    logic          locked;
    logic          illegal_code;
    logic          seq_error;
    logic [7:0]    err_count;

    johnson_seq_decoder #(.WIDTH(W), .LOCK_THRESH(THRESH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .code_in      (code_in),
        .count_out    (count_out),
        .count_valid  (count_valid),
        .locked       (locked),
        .illegal_code (illegal_code),
        .seq_error    (seq_error),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] cnt;
        logic          cv;
        logic          lk;
        logic          il;
        logic          se;
        logic [7:0]    err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: sequence table built from the successor rule, plus the
    // position of the last legal word and the length of the correct-step streak.
    logic [W-1:0] seq_tab [N];
    bit           have_ref = 0;
    int           last_idx = 0;
    int           streak   = 0;
    int           m_cnt    = 0;
    int           m_err    = 0;
    int           lock_need;

    function automatic int lookup(input logic [W-1:0] c);
        for (int i = 0; i < N; i++) begin
            if (seq_tab[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic step(input bit rst, input bit v, input logic [W-1:0] c);
        exp_t e;
        int   idx;
        @(negedge clk);
        reset_n  = !rst;
        in_valid = v;
        code_in  = c;
        e = '0;
        if (rst) begin
            have_ref = 0; last_idx = 0; streak = 0; m_cnt = 0; m_err = 0;
        end else if (v) begin
            idx = lookup(c);
            if (idx < 0) begin
                e.il = 1'b1;
                have_ref = 0;
                streak = 0;
                m_err++;
            end else begin
                e.cv = 1'b1;
                m_cnt = idx;
                if (!have_ref) begin
                    have_ref = 1; streak = 1; last_idx = idx;
                end else if (idx == last_idx) begin
                    // stall: nothing changes
                end else if (idx == (last_idx + 1) % N) begin
                    streak++; last_idx = idx;
                end else begin
                    e.se = 1'b1; streak = 1; last_idx = idx; m_err++;
                end
            end
        end
        e.cnt = IW'(m_cnt);
        e.lk  = have_ref && (streak >= lock_need);
`ifdef JSD_ERR_COUNTER_EN
        e.err = (m_err > 255) ? 8'hFF : 8'(m_err);
`else
        e.err = 8'h00;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: one output vector per clock, one line per transaction.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{cnt: count_out, cv: count_valid, lk: locked,
                      il: illegal_code, se: seq_error, err: err_count};
                checks++;
                txn++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL txn%0d outputs: got cnt=%0d cv=%b lk=%b il=%b se=%b err=%0d, want cnt=%0d cv=%b lk=%b il=%b se=%b err=%0d",
                             txn, a.cnt, a.cv, a.lk, a.il, a.se, a.err,
                             e.cnt, e.cv, e.lk, e.il, e.se, e.err);
                end else begin
                    $display("txn%0d ok cnt=%0d cv=%b lk=%b il=%b se=%b err=%0d",
                             txn, a.cnt, a.cv, a.lk, a.il, a.se, a.err);
                end
            end
        end
    end

    initial begin
        int r;
        int wait_cycles;
        logic [W-1:0] c;

        lock_need = (THRESH < 2) ? 2 : THRESH;
        seq_tab[0] = '0;
        for (int i = 1; i < N; i++) begin
            seq_tab[i] = {~seq_tab[i-1][0], seq_tab[i-1][W-1:1]};
        end

        // reset
        step(1, 0, 4'b0000);
        step(1, 1, 4'b1000);
        // 1: acquire lock
        step(0, 1, 4'b0000);
        step(0, 1, 4'b1000);
        step(0, 1, 4'b1100);
        // 2: run through the wrap
        step(0, 1, 4'b1110);
        step(0, 1, 4'b1111);
        step(0, 1, 4'b0111);
        step(0, 1, 4'b0011);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b1000);
        step(0, 1, 4'b1100);
        // 3: illegal word while locked
        step(0, 1, 4'b0110);
        // 4: relock, then skip a step
        step(0, 1, 4'b0011);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b1000);
        step(0, 1, 4'b1110);
        step(0, 1, 4'b1111);
        step(0, 1, 4'b0111);
        // 5: idle, then stall on the same word
        for (int i = 0; i < 5; i++) step(0, 0, 4'($urandom_range(0, 15)));
        step(0, 1, 4'b0111);
        step(0, 1, 4'b0111);
        step(0, 1, 4'b0011);
        // 6: reset while locked, then error saturation
        step(1, 1, 4'b0001);
        step(0, 0, 4'b0000);
        for (int i = 0; i < 300; i++) step(0, 1, 4'b0110);
        step(0, 1, 4'b1001);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 10)      c = seq_tab[have_ref ? (last_idx + 1) % N : $urandom_range(0, N-1)];
            else if (r < 12) c = seq_tab[last_idx];
            else if (r < 14) c = seq_tab[$urandom_range(0, N-1)];
            else             c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) step(1, 1, c);
            else step(0, (r != 19), c);
        end

        // drain: bounded wait for the monitor to empty the queue
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
